// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-fetch path: address/instruction
// widths, the HALT encoding, fetch FSM states and the fetch-queue entry layout.
package imem_pkg;

  localparam int ADDR_W = 5;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'hFFFF;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    addr_t  pc;
    instr_t word;
  } fetch_entry_t;

  // PC advance; the add truncates to ADDR_W so the last address wraps to 0
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue of fetch_entry_t with push/pop/flush.
// The head is kept in its own register so it holds the last entry once the queue drains.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         valid,
  output fetch_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             valid_r;
  fetch_entry_t     head_r;
  fetch_entry_t     head_nxt_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full  = (count_r == CNT_W'(DEPTH));
  assign valid = valid_r;
  assign head  = head_r;

  // Next occupancy and next head entry (the entry behind the head, or the incoming push)
  always_comb begin
    count_nxt_s = count_r;
    head_nxt_s  = head_r;
    if (flush) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
      if (pop) begin
        if (count_r > CNT_W'(1)) begin
          head_nxt_s = mem_r[ptr_inc(rd_ptr_r)];
        end else if (push) begin
          head_nxt_s = push_data;
        end else begin
          head_nxt_s = head_r;
        end
      end else if ((count_r == {CNT_W{1'b0}}) && push) begin
        head_nxt_s = push_data;
      end else begin
        head_nxt_s = head_r;
      end
    end
  end

  // Storage, pointers, occupancy and registered head/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else begin
      if (flush) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push) begin
          mem_r[wr_ptr_r] <= push_data;
          wr_ptr_r        <= ptr_inc(wr_ptr_r);
        end
        if (pop) begin
          rd_ptr_r <= ptr_inc(rd_ptr_r);
        end
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      head_r  <= head_nxt_s;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, captures imem words into the fetch queue,
// stops on HALT_WORD and restarts on a redirect, which also flushes the queue.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               halted
);

  fetch_state_t state_r;
  addr_t        pc_r;
  logic         halted_r;
  logic         deq_s;
  logic         can_enq_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  fetch_entry_t push_data_s;
  fetch_entry_t head_s;

  assign imem_addr   = pc_r;
  assign halted      = halted_r;
  assign out_pc      = head_s.pc;
  assign out_instr   = head_s.word;
  assign push_data_s = {pc_r, imem_instr};

  // Redirect outranks both dequeue and enqueue; a full queue may still take a word
  // in the same cycle its head leaves
  always_comb begin
    deq_s     = out_valid & out_ready;
    can_enq_s = ~full_s | deq_s;
    pop_s     = deq_s & ~redirect_valid;
    if (!redirect_valid && (state_r == FETCH) && can_enq_s) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Fetch FSM with PC and registered halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= FETCH;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      state_r  <= FETCH;
      pc_r     <= redirect_pc;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (push_s) begin
            if (imem_instr == HALT_WORD) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_inc(pc_r);
            end
          end
        end
        HALT: begin
          state_r  <= HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= FETCH;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .flush    (redirect_valid),
    .push_data(push_data_s),
    .full     (full_s),
    .valid    (out_valid),
    .head     (head_s)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus a randomized run
// compared against a queue-based reference model of the fetch rules.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [4:0]  redirect_pc = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_pc;
  logic [15:0] out_instr;
  logic        halted;

  logic [15:0] imem_mem [32];

  typedef struct {
    logic [4:0]  pc;
    logic [15:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_pc;
  logic        m_halt;
  logic [4:0]  m_last_pc;
  logic [15:0] m_last_w;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_mem[imem_addr];

  imem_fetch_ctrl #(
    .DEPTH   (DEPTH),
    .RESET_PC(5'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .halted        (halted)
  );

  task automatic model_reset();
    mq.delete();
    m_pc      = 5'd0;
    m_halt    = 1'b0;
    m_last_pc = 5'd0;
    m_last_w  = 16'd0;
  endtask

  // One clock edge of the fetch rules, using the values seen just before the edge
  task automatic model_edge(input logic rv, input logic [4:0] rpc, input logic rdy);
    int   sz;
    bit   deq;
    ent_t e;
    sz  = mq.size();
    deq = (sz != 0) && rdy;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 1'b0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (!m_halt && ((sz < DEPTH) || deq)) begin
        e.pc = m_pc;
        e.w  = imem_mem[m_pc];
        mq.push_back(e);
        if (e.w == 16'hFFFF) m_halt = 1'b1;
        else m_pc = (m_pc == 5'd31) ? 5'd0 : m_pc + 5'd1;
      end
    end
    if (mq.size() != 0) begin
      m_last_pc = mq[0].pc;
      m_last_w  = mq[0].w;
    end
  endtask

  task automatic step(input logic rv, input logic [4:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_edge(rv, rpc, rdy);
    #1;
  endtask

  task automatic do_reset();
    redirect_valid = 1'b0;
    redirect_pc    = 5'd0;
    out_ready      = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
    n_checks++; if (out_pc !== 5'd0) $display("FAIL reset_pc got %0d want 0", out_pc); else n_pass++;
    n_checks++; if (out_instr !== 16'h0000) $display("FAIL reset_instr got %h want 0000", out_instr); else n_pass++;
    n_checks++; if (imem_addr !== 5'd0) $display("FAIL reset_addr got %0d want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    logic [15:0] exp_w;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 5'd0, 1'b1);
      exp_w = 16'h1000 + 16'(i);
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
      n_checks++; if (out_pc !== 5'(i)) $display("FAIL stream_pc[%0d] got %0d want %0d", i, out_pc, i); else n_pass++;
      n_checks++; if (out_instr !== exp_w) $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, exp_w); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 5'd0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_pc !== 5'd0) $display("FAIL bp_head got %0d want 0", out_pc); else n_pass++;
    n_checks++; if (imem_addr !== 5'd2) $display("FAIL bp_addr got %0d want 2", imem_addr); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 5'(k))
        $display("FAIL bp_order[%0d] got valid=%b pc=%0d want valid=1 pc=%0d", k, out_valid, out_pc, k);
      else n_pass++;
      step(1'b0, 5'd0, 1'b1);
    end
  endtask

  task automatic test_halt();
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b0, 5'd0, 1'b1);
      if (out_valid === 1'b1 && out_pc === 5'd6) seen = 1'b1;
    end
    n_checks++; if (!seen) $display("FAIL halt_seen got no pc 6 within 20 cycles want pc 6"); else n_pass++;
    n_checks++; if (out_instr !== 16'hFFFF) $display("FAIL halt_word got %h want ffff", out_instr); else n_pass++;
    n_checks++; if (halted !== m_halt) $display("FAIL halt_flag got %b want %b", halted, m_halt); else n_pass++;
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1);
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_stay got %b want 1", halted); else n_pass++;
    n_checks++; if (imem_addr !== 5'd6) $display("FAIL halt_addr got %0d want 6", imem_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL halt_drain got %b want 0", out_valid); else n_pass++;
    step(1'b1, 5'd3, 1'b1);
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_clear got %b want 0", halted); else n_pass++;
    step(1'b0, 5'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 5'd3)
      $display("FAIL halt_resume got valid=%b pc=%0d want valid=1 pc=3", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_full();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b0);
    step(1'b1, 5'd17, 1'b1);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rf_flush got %b want 0", out_valid); else n_pass++;
    step(1'b0, 5'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 5'd17)
      $display("FAIL rf_target got valid=%b pc=%0d want valid=1 pc=17", out_valid, out_pc);
    else n_pass++;
    n_checks++; if (out_instr !== 16'h1011) $display("FAIL rf_instr got %h want 1011", out_instr); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 5'd31, 1'b1);
    step(1'b0, 5'd0, 1'b1);
    n_checks++; if (out_pc !== 5'd31 || out_instr !== 16'h101F)
      $display("FAIL wrap_31 got pc=%0d instr=%h want pc=31 instr=101f", out_pc, out_instr);
    else n_pass++;
    step(1'b0, 5'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 5'd0 || out_instr !== 16'h1000)
      $display("FAIL wrap_0 got valid=%b pc=%0d instr=%h want 1/0/1000", out_valid, out_pc, out_instr);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 5'd0, 1'b1);
    n_checks++; if (halted !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL ar_pre got halted=%b valid=%b want 1/1", halted, out_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL ar_immediate got valid=%b halted=%b want 0/0", out_valid, halted);
    else n_pass++;
    n_checks++; if (out_pc !== 5'd0 || imem_addr !== 5'd0)
      $display("FAIL ar_regs got out_pc=%0d addr=%0d want 0/0", out_pc, imem_addr);
    else n_pass++;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 5'd0, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 5'd0)
      $display("FAIL ar_restart got valid=%b pc=%0d want 1/0", out_valid, out_pc);
    else n_pass++;
  endtask

  task automatic test_random();
    logic       rv;
    logic [4:0] rpc;
    logic       rdy;
    logic       m_valid;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rpc = 5'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 3) != 0);
      step(rv, rpc, rdy);
      m_valid = (mq.size() != 0);
      n_checks++; if (out_valid !== m_valid) $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, m_valid); else n_pass++;
      n_checks++; if (out_pc !== m_last_pc) $display("FAIL rnd_pc[%0d] got %0d want %0d", i, out_pc, m_last_pc); else n_pass++;
      n_checks++; if (out_instr !== m_last_w) $display("FAIL rnd_instr[%0d] got %h want %h", i, out_instr, m_last_w); else n_pass++;
      n_checks++; if (halted !== m_halt) $display("FAIL rnd_halted[%0d] got %b want %b", i, halted, m_halt); else n_pass++;
      n_checks++; if (imem_addr !== m_pc) $display("FAIL rnd_addr[%0d] got %0d want %0d", i, imem_addr, m_pc); else n_pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 32; k++) imem_mem[k] = 16'h1000 + 16'(k);
    imem_mem[6] = 16'hFFFF;
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_halt();
    test_redirect_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
